// File: rtl/button_event_decoder.sv
//------------------------------------------------------------------------------
// button_event_decoder
//
// Purpose:
//   Turns a debounced button level into discrete user-interface events.
//   These are press and release edges, a confirmed single click, a double
//   click, a long press, and auto-repeat ticks while a long press is held.
//   All timing comes from a single shared 24-bit counter. The counter is
//   cleared whenever the decoder enters a new state.
//
// Parameters:
//   c_LONG_LIMIT    clocks a press must be held before it counts as long
//   c_GAP_LIMIT     longest release-to-press gap still treated as a double
//   c_REPEAT_PERIOD clocks between auto-repeat pulses while long-held
//   (each must lie in 2 .. 2^24-1)
//
// Ports:
//   i_Clk         clock, rising edge
//   i_Rst_n       synchronous active-low reset
//   i_data        debounced button level, 1 = pressed
//   i_repeat_en   level enable for o_repeat
//   o_press       one-clock pulse per press
//   o_release     one-clock pulse per release
//   o_single      one-clock pulse when a short click is confirmed
//   o_double      one-clock pulse when a double click is detected
//   o_long        one-clock pulse when a long press is detected
//   o_repeat      one-clock auto-repeat pulse
//   o_long_held   level, high while the decoder is in LONG_HELD
//------------------------------------------------------------------------------
module button_event_decoder #(
   parameter int unsigned c_LONG_LIMIT    = 12500000,
   parameter int unsigned c_GAP_LIMIT     = 7500000,
   parameter int unsigned c_REPEAT_PERIOD = 2500000
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_data,
   input  logic i_repeat_en,
   output logic o_press,
   output logic o_release,
   output logic o_single,
   output logic o_double,
   output logic o_long,
   output logic o_repeat,
   output logic o_long_held
);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_GAP,
      SECOND
   } state_t;

   // Terminal counts. Each limit fires when the counter reaches limit-1,
   // so the matching pulse appears exactly 'limit' clocks after the
   // pulse that caused the state entry.
   localparam logic [23:0] LONG_LAST   = 24'(c_LONG_LIMIT - 1);
   localparam logic [23:0] GAP_LAST    = 24'(c_GAP_LIMIT - 1);
   localparam logic [23:0] REPEAT_LAST = 24'(c_REPEAT_PERIOD - 1);

   state_t      state;
   logic [23:0] count;
   logic        r_prev;
   logic        rise;
   logic        fall;

   assign rise = i_data & ~r_prev;
   assign fall = ~i_data & r_prev;

   // Single registered FSM. Pulse outputs default low each clock and are
   // raised only on the edge that detects their condition.
   // The counter runs freely and is cleared on each state entry.
   // Where two events land on the same edge, the button edge is tested
   // first, so release beats long/repeat and a second press beats the
   // gap timeout.
   // During reset r_prev follows the button, so a button already held
   // at reset exit is not mistaken for a fresh press.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state       <= IDLE;
         count       <= 24'd0;
         r_prev      <= i_data;
         o_press     <= 1'b0;
         o_release   <= 1'b0;
         o_single    <= 1'b0;
         o_double    <= 1'b0;
         o_long      <= 1'b0;
         o_repeat    <= 1'b0;
         o_long_held <= 1'b0;
      end else begin
         r_prev    <= i_data;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_single  <= 1'b0;
         o_double  <= 1'b0;
         o_long    <= 1'b0;
         o_repeat  <= 1'b0;
         count     <= count + 24'd1;

         case (state)
            IDLE: begin
               if (rise) begin
                  o_press <= 1'b1;
                  state   <= PRESSED;
                  count   <= 24'd0;
               end
            end

            PRESSED: begin
               if (fall) begin
                  o_release <= 1'b1;
                  state     <= WAIT_GAP;
                  count     <= 24'd0;
               end else if (count == LONG_LAST) begin
                  o_long      <= 1'b1;
                  o_long_held <= 1'b1;
                  state       <= LONG_HELD;
                  count       <= 24'd0;
               end
            end

            LONG_HELD: begin
               // With repeat disabled the counter is parked at zero, so
               // enabling repeat later gives a full period before the
               // first tick.
               if (fall) begin
                  o_release   <= 1'b1;
                  o_long_held <= 1'b0;
                  state       <= IDLE;
                  count       <= 24'd0;
               end else if (!i_repeat_en) begin
                  count <= 24'd0;
               end else if (count == REPEAT_LAST) begin
                  o_repeat <= 1'b1;
                  count    <= 24'd0;
               end
            end

            WAIT_GAP: begin
               if (rise) begin
                  o_press  <= 1'b1;
                  o_double <= 1'b1;
                  state    <= SECOND;
                  count    <= 24'd0;
               end else if (count == GAP_LAST) begin
                  o_single <= 1'b1;
                  state    <= IDLE;
                  count    <= 24'd0;
               end
            end

            SECOND: begin
               // The second press of a double click never turns into a
               // long press, so only its release matters here.
               if (fall) begin
                  o_release <= 1'b1;
                  state     <= IDLE;
                  count     <= 24'd0;
               end
            end

            default: begin
               o_long_held <= 1'b0;
               state       <= IDLE;
               count       <= 24'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
//------------------------------------------------------------------------------
// tb_button_event_decoder
//
// Self-checking bench for button_event_decoder, using the short simulation
// limits (long 20, gap 10, repeat 5).
//
// The stimulus side drives inputs on the falling edge. It feeds the same
// inputs to a timestamp-based reference model, which queues the output
// vector expected after the next rising edge.
//
// A separate monitor samples the DUT just after each rising edge. Whenever
// the DUT shows activity, or an expectation is due, the monitor pops the
// queue and compares.
//------------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam int LONG_LIM = 20;
   localparam int GAP_LIM  = 10;
   localparam int REP_PER  = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic data;
   logic repeat_en;
   logic press, release_p, single, double_p, long_p, repeat_p, long_held;

   int edge_num   = 0;
   int compared   = 0;
   int mismatched = 0;

   // Expected vector order: press, release, single, double, long, repeat, long_held
   typedef struct {
      int         n;
      logic [6:0] vec;
   } exp_t;

   exp_t exp_q[$];

   button_event_decoder #(
      .c_LONG_LIMIT   (LONG_LIM),
      .c_GAP_LIMIT    (GAP_LIM),
      .c_REPEAT_PERIOD(REP_PER)
   ) dut (
      .i_Clk      (clk),
      .i_Rst_n    (rst_n),
      .i_data     (data),
      .i_repeat_en(repeat_en),
      .o_press    (press),
      .o_release  (release_p),
      .o_single   (single),
      .o_double   (double_p),
      .o_long     (long_p),
      .o_repeat   (repeat_p),
      .o_long_held(long_held)
   );

   always #5 clk = ~clk;

   // Rising-edge index; at any falling edge it names the next rising edge.
   always @(posedge clk) edge_num <= edge_num + 1;

   //---------------------------------------------------------------------------
   // Reference model. It describes a click by when things happened:
   //   - when the button went down,
   //   - when it came up,
   //   - whether this is the second press or a long hold.
   // Each timeout is "now minus timestamp equals limit".
   //---------------------------------------------------------------------------
   logic m_prev     = 1'b0;
   bit   m_engaged  = 0;
   bit   m_down     = 0;
   bit   m_second   = 0;
   bit   m_long     = 0;
   int   m_press_at = 0;
   int   m_rel_at   = 0;
   int   m_rep_ref  = 0;

   task automatic modelStep(input logic d, input logic en, input logic rn, input int n);
      logic [6:0] v;
      logic       rise, fall;
      exp_t       e;
      v    = 7'd0;
      rise = d & ~m_prev;
      fall = ~d & m_prev;
      if (!rn) begin
         m_engaged = 0;
         m_down    = 0;
         m_second  = 0;
         m_long    = 0;
         e.n   = n;
         e.vec = 7'd0;
         exp_q.push_back(e);
      end else begin
         if (!m_engaged) begin
            if (rise) begin
               v[6]       = 1'b1;
               m_engaged  = 1;
               m_down     = 1;
               m_second   = 0;
               m_long     = 0;
               m_press_at = n;
            end
         end else if (m_down && m_long) begin
            if (fall) begin
               v[5]      = 1'b1;
               m_engaged = 0;
               m_down    = 0;
               m_long    = 0;
            end else if (!en) begin
               m_rep_ref = n;
            end else if (n - m_rep_ref == REP_PER) begin
               v[1]      = 1'b1;
               m_rep_ref = n;
            end
         end else if (m_down && m_second) begin
            if (fall) begin
               v[5]      = 1'b1;
               m_engaged = 0;
               m_down    = 0;
               m_second  = 0;
            end
         end else if (m_down) begin
            if (fall) begin
               v[5]     = 1'b1;
               m_down   = 0;
               m_rel_at = n;
            end else if (n - m_press_at == LONG_LIM) begin
               v[2]      = 1'b1;
               m_long    = 1;
               m_rep_ref = n;
            end
         end else begin
            if (rise) begin
               v[6]     = 1'b1;
               v[3]     = 1'b1;
               m_down   = 1;
               m_second = 1;
            end else if (n - m_rel_at == GAP_LIM) begin
               v[4]      = 1'b1;
               m_engaged = 0;
            end
         end
         v[0] = m_engaged && m_down && m_long;
         if (v != 7'd0) begin
            e.n   = n;
            e.vec = v;
            exp_q.push_back(e);
         end
      end
      m_prev = d;
   endtask

   // Holds one input pattern for 'cycles' rising edges, modelling each one.
   task automatic applyStimulus(input logic d, input logic en, input logic rn, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         data      = d;
         repeat_en = en;
         rst_n     = rn;
         modelStep(d, en, rn, edge_num);
         @(negedge clk);
      end
   endtask

   //---------------------------------------------------------------------------
   // Monitor / scoreboard.
   //---------------------------------------------------------------------------
   task automatic checkOutput(input int cur);
      logic [6:0] act;
      exp_t       e;
      act = {press, release_p, single, double_p, long_p, repeat_p, long_held};
      while (exp_q.size() > 0 && exp_q[0].n < cur) begin
         e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL missed_event edge %0d: got nothing, expected %b", e.n, e.vec);
      end
      if (act !== 7'd0 || (exp_q.size() > 0 && exp_q[0].n == cur)) begin
         compared++;
         if (exp_q.size() > 0 && exp_q[0].n == cur) begin
            e = exp_q.pop_front();
            if (act !== e.vec) begin
               mismatched++;
               $display("[TB] FAIL outputs edge %0d: got %b, expected %b", cur, act, e.vec);
            end
         end else begin
            mismatched++;
            $display("[TB] FAIL unexpected_output edge %0d: got %b, expected 0000000", cur, act);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      checkOutput(edge_num - 1);
   end

   //---------------------------------------------------------------------------
   // Stimulus: directed scenarios first, then random segments.
   //---------------------------------------------------------------------------
   initial begin
      logic d;
      exp_t e;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 3);

      // Short click becomes a single
      applyStimulus(1'b1, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);

      // Double click
      applyStimulus(1'b1, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 4);
      applyStimulus(1'b1, 1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);

      // Long hold with repeat; the release coincides with a repeat tick
      applyStimulus(1'b1, 1'b1, 1'b1, 40);
      applyStimulus(1'b0, 1'b1, 1'b1, 5);

      // Release on exactly the long-limit edge
      applyStimulus(1'b1, 1'b0, 1'b1, 20);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);

      // Second press on exactly the gap-timeout edge
      applyStimulus(1'b1, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 10);
      applyStimulus(1'b1, 1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);

      // Button held through reset gives no press until re-pressed
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 1'b1, 5);
      applyStimulus(1'b0, 1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 1'b1, 15);

      // Reset during the gap wait, then during a long hold
      applyStimulus(1'b1, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);
      applyStimulus(1'b1, 1'b1, 1'b1, 25);
      applyStimulus(1'b1, 1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b1, 5);
      applyStimulus(1'b1, 1'b0, 1'b1, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 15);

      // Random segments: toggling levels, random repeat enable, rare resets
      d = 1'b0;
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                          $urandom_range(1, 3));
         end
         d = ~d;
         applyStimulus(d, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 30));
      end

      // Let any pending single confirm, then drain
      applyStimulus(1'b0, 1'b0, 1'b1, 30);
      @(negedge clk);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL leftover_expectation edge %0d: got nothing, expected %b", e.n, e.vec);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
